// File: rtl/ram_arb_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the RAM port arbiter.
// Port indices double as the round-robin "last granted" encoding.
package ram_arb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } arb_state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_SPI = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_rr_pick2.sv
`timescale 1ns/1ps
// Two-way round-robin winner select (combinational).
// An active lock masks every port except the lock owner.
module rr_pick2
   import ram_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   input  logic       lock_vld,
   input  logic       lock_own,
   output logic       any,
   output logic       win
);

   logic [1:0] eff;

   // mask requests down to the lock owner while a lock is active
   always_comb begin
      eff = req;
      if (lock_vld)
         eff = req & (lock_own ? 2'b10 : 2'b01);
   end

   // single requester wins outright; a tie goes to the port not granted last
   always_comb begin
      any = |eff;
      win = PORT_CPU;
      if (eff == 2'b11)
         win = ~last;
      else if (eff[1])
         win = PORT_SPI;
   end

endmodule

// File: rtl/ram_port_arbiter.sv
`timescale 1ns/1ps
// Shares one single-port RAM between the CPU and the SPI bridge.
// Optional RAM_ARB_LOCK_EN adds cpu_lock/spi_lock burst locking.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_gnt,
   output logic                  cpu_rvalid,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   input  logic                  spi_req,
   input  logic                  spi_we,
   input  logic [ADDR_WIDTH-1:0] spi_addr,
   input  logic [DATA_WIDTH-1:0] spi_wdata,
   output logic                  spi_gnt,
   output logic                  spi_rvalid,
   output logic [DATA_WIDTH-1:0] spi_rdata,
`ifdef RAM_ARB_LOCK_EN
   input  logic                  cpu_lock,
   input  logic                  spi_lock,
`endif
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic                  busy
);

   arb_state_t state;
   arb_state_t state_nxt;

   logic last;
   logic sel;
   logic any;
   logic win;
   logic start;
   logic rd_done;
   logic lock_act;
   logic lock_own;

`ifdef RAM_ARB_LOCK_EN
   logic [1:0] lock_in;
   logic       lock_vld;

   assign lock_in  = {spi_lock, cpu_lock};
   assign lock_act = lock_vld && lock_in[lock_own];

   // lock owner armed at each grant, released once its lock drops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_vld <= 1'b0;
         lock_own <= PORT_CPU;
      end else if (start) begin
         lock_vld <= lock_in[win];
         lock_own <= win;
      end else if (lock_vld && !lock_in[lock_own]) begin
         lock_vld <= 1'b0;
      end
   end
`else
   assign lock_act = 1'b0;
   assign lock_own = PORT_CPU;
`endif

   rr_pick2 u_pick (
      .req      ({spi_req, cpu_req}),
      .last     (last),
      .lock_vld (lock_act),
      .lock_own (lock_own),
      .any      (any),
      .win      (win)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next state: one ACCESS cycle per accepted request
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (any) state_nxt = ACCESS;
         ACCESS:  state_nxt = IDLE;
      endcase
   end

   // FSM outputs: accept in IDLE, complete reads at the end of ACCESS
   always_comb begin
      start   = (state == IDLE) && any;
      busy    = (state == ACCESS);
      rd_done = (state == ACCESS) && !ram_we;
   end

   // RAM port registers: latch the winner's request for one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         cpu_gnt   <= 1'b0;
         spi_gnt   <= 1'b0;
         sel       <= PORT_CPU;
         last      <= PORT_SPI;
      end else if (start) begin
         ram_en    <= 1'b1;
         ram_we    <= win ? spi_we : cpu_we;
         ram_addr  <= win ? spi_addr : cpu_addr;
         ram_wdata <= win ? spi_wdata : cpu_wdata;
         cpu_gnt   <= (win == PORT_CPU);
         spi_gnt   <= (win == PORT_SPI);
         sel       <= win;
         last      <= win;
      end else begin
         ram_en  <= 1'b0;
         ram_we  <= 1'b0;
         cpu_gnt <= 1'b0;
         spi_gnt <= 1'b0;
      end
   end

   // read return: capture RAM data for the port that owned the read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_rvalid <= 1'b0;
         spi_rvalid <= 1'b0;
         cpu_rdata  <= '0;
         spi_rdata  <= '0;
      end else begin
         cpu_rvalid <= rd_done && (sel == PORT_CPU);
         spi_rvalid <= rd_done && (sel == PORT_SPI);
         if (rd_done && (sel == PORT_CPU))
            cpu_rdata <= ram_rdata;
         if (rd_done && (sel == PORT_SPI))
            spi_rdata <= ram_rdata;
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
`timescale 1ns/1ps
// Bench for ram_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level arbitration and memory model.
module tb_ram_port_arbiter;

   localparam int AW = 8;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          spi_req = 1'b0, spi_we = 1'b0;
   logic [AW-1:0] spi_addr = '0;
   logic [DW-1:0] spi_wdata = '0;
`ifdef RAM_ARB_LOCK_EN
   logic          cpu_lock = 1'b0, spi_lock = 1'b0;
`endif
   logic          cpu_gnt, cpu_rvalid, spi_gnt, spi_rvalid;
   logic [DW-1:0] cpu_rdata, spi_rdata;
   logic          ram_en, ram_we, busy;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata, ram_rdata;

   logic [DW-1:0] mem [0:255];
   logic [DW-1:0] ref_mem [0:255];

   int total = 0;
   int bad = 0;
   int cnt_sg = 0;
   int cnt_srv = 0;

   logic [110:0] all_out;
   assign all_out = {cpu_gnt, cpu_rvalid, cpu_rdata, spi_gnt, spi_rvalid,
                     spi_rdata, ram_en, ram_we, ram_addr, ram_wdata, busy};

   ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
      .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr),
      .spi_wdata(spi_wdata), .spi_gnt(spi_gnt),
      .spi_rvalid(spi_rvalid), .spi_rdata(spi_rdata),
`ifdef RAM_ARB_LOCK_EN
      .cpu_lock(cpu_lock), .spi_lock(spi_lock),
`endif
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_word(input int i);
      return 32'h0122_0000 + 32'(i) * 32'h10;
   endfunction

   // single-port RAM: combinational read, write on the rising edge
   assign ram_rdata = mem[ram_addr];
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = init_word(i);
      forever begin
         @(posedge clk);
         if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
      end
   end

   always @(negedge clk) begin
      cnt_sg  <= cnt_sg + int'(spi_gnt);
      cnt_srv <= cnt_srv + int'(spi_rvalid);
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drop_all;
      cpu_req = 1'b0;
      spi_req = 1'b0;
`ifdef RAM_ARB_LOCK_EN
      cpu_lock = 1'b0;
      spi_lock = 1'b0;
`endif
   endtask

   task automatic do_reset;
      drop_all();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic do_access(input logic port, input logic we,
                            input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd,
                            output int lat, output logic [DW-1:0] rd);
      logic          g;
      logic          rv;
      logic [DW-1:0] expd;
      if (port) begin
         spi_req = 1'b1; spi_we = we; spi_addr = addr; spi_wdata = wd;
      end else begin
         cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      end
      lat = 0;
      g = 1'b0;
      rd = '0;
      while (!g && lat < 10) begin
         step();
         lat++;
         g = port ? spi_gnt : cpu_gnt;
      end
      if (port) spi_req = 1'b0;
      else cpu_req = 1'b0;
      total++;
      if (!g) begin
         bad++;
         $display("FAIL acc_grant port=%0d got=0 exp=1", port);
      end else begin
         total++;
         if ({ram_en, ram_we, ram_addr} !== {1'b1, we, addr} ||
             (we && ram_wdata !== wd)) begin
            bad++;
            $display("FAIL acc_ramport got=%b/%b/%h/%h exp=1/%b/%h/%h",
                     ram_en, ram_we, ram_addr, ram_wdata, we, addr, wd);
         end
         if (we) begin
            ref_mem[addr] = wd;
         end else begin
            expd = ref_mem[addr];
            step();
            rv = port ? spi_rvalid : cpu_rvalid;
            rd = port ? spi_rdata : cpu_rdata;
            total++;
            if ({rv, rd} !== {1'b1, expd}) begin
               bad++;
               $display("FAIL acc_rdata port=%0d got=%b/%h exp=1/%h",
                        port, rv, rd, expd);
            end
         end
      end
   endtask

   task automatic test_reset;
      drop_all();
      rst_n = 1'b0;
      #2;
      total++;
      if (all_out !== '0) begin
         bad++;
         $display("FAIL reset_outs got=%h exp=0", all_out);
      end
      do_reset();
      total++;
      if (all_out !== '0) begin
         bad++;
         $display("FAIL reset_idle got=%h exp=0", all_out);
      end
   endtask

   task automatic test_cpu_read;
      int            lat, s0, s1;
      logic [DW-1:0] rd;
      s0 = cnt_sg;
      s1 = cnt_srv;
      do_access(1'b0, 1'b0, 8'h00, '0, lat, rd);
      step();
      total++;
      if (lat !== 1) begin
         bad++;
         $display("FAIL cpu_rd_lat got=%0d exp=1", lat);
      end
      total++;
      if (rd !== 32'h0122_0000) begin
         bad++;
         $display("FAIL cpu_rd_word0 got=%h exp=01220000", rd);
      end
      total++;
      if ((cnt_sg - s0) !== 0 || (cnt_srv - s1) !== 0) begin
         bad++;
         $display("FAIL cpu_rd_spi_quiet got=%0d/%0d exp=0/0",
                  cnt_sg - s0, cnt_srv - s1);
      end
   endtask

   task automatic test_write_read;
      int            lat, s1;
      logic [DW-1:0] rd;
      s1 = cnt_srv;
      do_access(1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF, lat, rd);
      do_access(1'b0, 1'b0, 8'h10, '0, lat, rd);
      step();
      total++;
      if (rd !== 32'hDEAD_BEEF) begin
         bad++;
         $display("FAIL wr_rd_data got=%h exp=deadbeef", rd);
      end
      total++;
      if ((cnt_srv - s1) !== 0) begin
         bad++;
         $display("FAIL wr_no_rvalid got=%0d exp=0", cnt_srv - s1);
      end
   endtask

   task automatic test_tie;
      logic ec, es, rc, rs;
      do_reset();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01;
      spi_req = 1'b1; spi_we = 1'b0; spi_addr = 8'h02;
      for (int k = 1; k <= 8; k++) begin
         step();
         ec = (k % 2 == 1) && ((k / 2) % 2 == 0);
         es = (k % 2 == 1) && ((k / 2) % 2 == 1);
         rc = (k % 2 == 0) && (((k - 1) / 2) % 2 == 0);
         rs = (k % 2 == 0) && (((k - 1) / 2) % 2 == 1);
         if (k == 8) drop_all();
         total++;
         if ({cpu_gnt, spi_gnt, cpu_rvalid, spi_rvalid} !== {ec, es, rc, rs}) begin
            bad++;
            $display("FAIL tie_order k=%0d got=%b exp=%b", k,
                     {cpu_gnt, spi_gnt, cpu_rvalid, spi_rvalid}, {ec, es, rc, rs});
         end
      end
      step();
   endtask

   task automatic test_starvation;
      int   acc;
      logic got_s, got_c;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h03;
      repeat (4) step();
      spi_req = 1'b1; spi_we = 1'b1; spi_addr = 8'h30; spi_wdata = 32'hC0DE_0030;
      acc = 0;
      got_s = 1'b0;
      for (int k = 0; k < 10 && !got_s; k++) begin
         step();
         if (cpu_gnt) acc++;
         if (spi_gnt) begin
            got_s = 1'b1;
            spi_req = 1'b0;
            ref_mem[8'h30] = 32'hC0DE_0030;
         end
      end
      total++;
      if (!got_s || acc > 1) begin
         bad++;
         $display("FAIL starve_spi got=%b/%0d exp=1/<=1", got_s, acc);
      end
      got_c = 1'b0;
      for (int k = 0; k < 4 && !got_c; k++) begin
         step();
         got_c = cpu_gnt;
      end
      cpu_req = 1'b0;
      total++;
      if (!got_c) begin
         bad++;
         $display("FAIL starve_cpu_after got=0 exp=1");
      end
      step();
      step();
   endtask

   task automatic test_reset_mid_access;
      logic g;
      spi_req = 1'b1; spi_we = 1'b1; spi_addr = 8'h20; spi_wdata = 32'h5555_AAAA;
      g = 1'b0;
      for (int k = 0; k < 5 && !g; k++) begin
         step();
         g = spi_gnt;
      end
      total++;
      if (!g || ram_en !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_grant got=%b/%b exp=1/1", g, ram_en);
      end
      rst_n = 1'b0;
      spi_req = 1'b0;
      #1;
      total++;
      if (all_out !== '0) begin
         bad++;
         $display("FAIL rst_mid_outs got=%h exp=0", all_out);
      end
      step();
      total++;
      if (mem[8'h20] !== ref_mem[8'h20]) begin
         bad++;
         $display("FAIL rst_mid_mem got=%h exp=%h", mem[8'h20], ref_mem[8'h20]);
      end
      rst_n = 1'b1;
      step();
   endtask

`ifdef RAM_ARB_LOCK_EN
   task automatic test_lock;
      int   ns;
      logic early, got_c;
      do_reset();
      spi_req = 1'b1; spi_we = 1'b1; spi_lock = 1'b1;
      spi_addr = 8'h40; spi_wdata = 32'h1000_0000;
      ns = 0;
      early = 1'b0;
      for (int k = 0; k < 12 && ns < 3; k++) begin
         step();
         cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
         if (cpu_gnt) early = 1'b1;
         if (spi_gnt) begin
            ref_mem[spi_addr] = spi_wdata;
            ns++;
            spi_addr = spi_addr + 8'h1;
            spi_wdata = spi_wdata + 32'h1;
            if (ns == 3) begin
               spi_req = 1'b0;
               spi_lock = 1'b0;
            end
         end
      end
      total++;
      if (ns !== 3 || early) begin
         bad++;
         $display("FAIL lock_burst got=%0d/%b exp=3/0", ns, early);
      end
      got_c = 1'b0;
      for (int k = 0; k < 4 && !got_c; k++) begin
         step();
         got_c = cpu_gnt;
      end
      cpu_req = 1'b0;
      total++;
      if (!got_c) begin
         bad++;
         $display("FAIL lock_release got=0 exp=1");
      end
      step();
      step();
   endtask
`endif

   task automatic test_random;
      logic          p_req [2];
      logic          p_we [2];
      logic [AW-1:0] p_addr [2];
      logic [DW-1:0] p_wd [2];
      logic [DW-1:0] e_rd [2];
      logic          e_rv [2];
      logic          acc, a_port, a_we, last, nacc;
      logic [AW-1:0] a_addr;
      logic [DW-1:0] a_wd;
      do_reset();
      for (int k = 0; k < 2; k++) begin
         p_req[k] = 1'b0; p_we[k] = 1'b0; p_addr[k] = '0; p_wd[k] = '0;
         e_rd[k] = '0; e_rv[k] = 1'b0;
      end
      acc = 1'b0; a_port = 1'b0; a_we = 1'b0; a_addr = '0; a_wd = '0;
      last = 1'b1;
      for (int c = 0; c < 400; c++) begin
         total++;
         if ({cpu_gnt, spi_gnt, busy, ram_en} !==
             {acc && !a_port, acc && a_port, acc, acc}) begin
            bad++;
            $display("FAIL rnd_ctrl c=%0d got=%b exp=%b", c,
                     {cpu_gnt, spi_gnt, busy, ram_en},
                     {acc && !a_port, acc && a_port, acc, acc});
         end
         if (acc) begin
            total++;
            if ({ram_we, ram_addr, ram_wdata} !== {a_we, a_addr, a_wd}) begin
               bad++;
               $display("FAIL rnd_port c=%0d got=%b/%h/%h exp=%b/%h/%h", c,
                        ram_we, ram_addr, ram_wdata, a_we, a_addr, a_wd);
            end
         end
         total++;
         if ({cpu_rvalid, cpu_rdata, spi_rvalid, spi_rdata} !==
             {e_rv[0], e_rd[0], e_rv[1], e_rd[1]}) begin
            bad++;
            $display("FAIL rnd_read c=%0d got=%b/%h/%b/%h exp=%b/%h/%b/%h", c,
                     cpu_rvalid, cpu_rdata, spi_rvalid, spi_rdata,
                     e_rv[0], e_rd[0], e_rv[1], e_rd[1]);
         end
         e_rv[0] = 1'b0;
         e_rv[1] = 1'b0;
         nacc = 1'b0;
         if (acc) begin
            if (a_we) begin
               ref_mem[a_addr] = a_wd;
            end else begin
               e_rd[a_port] = ref_mem[a_addr];
               e_rv[a_port] = 1'b1;
            end
            p_req[a_port] = 1'b0;
         end
         for (int k = 0; k < 2; k++) begin
            if (!p_req[k] && $urandom_range(0, 2) != 0) begin
               p_req[k]  = 1'b1;
               p_we[k]   = 1'($urandom_range(0, 1));
               p_addr[k] = AW'($urandom_range(0, 15));
               p_wd[k]   = $urandom;
            end
         end
         cpu_req = p_req[0]; cpu_we = p_we[0];
         cpu_addr = p_addr[0]; cpu_wdata = p_wd[0];
         spi_req = p_req[1]; spi_we = p_we[1];
         spi_addr = p_addr[1]; spi_wdata = p_wd[1];
         if (!acc && (p_req[0] || p_req[1])) begin
            if (p_req[0] && p_req[1]) a_port = !last;
            else a_port = p_req[1];
            a_we = p_we[a_port];
            a_addr = p_addr[a_port];
            a_wd = p_wd[a_port];
            last = a_port;
            nacc = 1'b1;
         end
         acc = nacc;
         step();
      end
      drop_all();
      step();
      step();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      test_reset();
      test_cpu_read();
      test_write_read();
      test_tie();
      test_starvation();
      test_reset_mid_access();
`ifdef RAM_ARB_LOCK_EN
      test_lock();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port instruction/data RAM between two requesters: the CPU (port 0) and the SPI loader/debug bridge (port 1).
- Accepts per-port request/grant transactions, picks a winner round-robin and drives the RAM port from registered signals.
- Returns registered read data with a valid pulse.
- Sits between the CPU core, the SPI slave and single_port_ram. Its ram_* outputs connect to the RAM's port-interface signals en/we/addr/wdata/rdata.

Parameters:
- ADDR_WIDTH, 8, RAM word-address width.
- DATA_WIDTH, 32, RAM word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cpu_req  input  1  CPU access request; held until cpu_gnt.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  ADDR_WIDTH  word address.
- cpu_wdata  input  DATA_WIDTH  write data.
- cpu_gnt  output  1  one-cycle pulse: request accepted; RAM access occurs this cycle.
- cpu_rvalid  output  1  one-cycle pulse: cpu_rdata valid.
- cpu_rdata  output  DATA_WIDTH  read data; held until the next CPU read completes.
- spi_req, spi_we, spi_addr, spi_wdata, spi_gnt, spi_rvalid, spi_rdata: same as the CPU port, for the SPI requester.
- ram_en  output  1  RAM enable.
- ram_we  output  1  RAM write enable.
- ram_addr  output  ADDR_WIDTH  RAM address.
- ram_wdata  output  DATA_WIDTH  RAM write data.
- ram_rdata  input  DATA_WIDTH  RAM combinational read data.
- busy  output  1  high while in ACCESS.

Behaviour:
- Reset values (asynchronous, while rst_n = 0):
  - All outputs 0; state IDLE.
  - last_gnt = SPI, so the CPU wins the first tie.
- FSM states: IDLE, ACCESS.
- IDLE:
  - Requests are sampled only in IDLE.
  - Neither port requesting: stay in IDLE.
  - One port requesting: that port wins, regardless of last_gnt.
  - Both requesting: the port not equal to last_gnt wins.
  - On the clock edge: latch the winner's we/addr/wdata into the ram_* registers, set ram_en = 1, set the winner's gnt = 1, set last_gnt = winner, go to ACCESS.
- ACCESS (exactly one cycle):
  - ram_en = 1, busy = 1, winner's gnt = 1.
  - Write: RAM updates at the edge ending ACCESS.
  - Read: ram_rdata is captured into the winner's rdata register at the edge ending ACCESS; the winner's rvalid is 1 during the following cycle.
  - Next state is always IDLE; ram_en, ram_we and gnt return to 0.
- Timing (request sampled at the edge ending cycle N):
  - gnt in cycle N+1.
  - Read data and rvalid in cycle N+2.
  - Maximum throughput: one access every 2 cycles.
- Requester protocol:
  - Hold req, we, addr and wdata stable until gnt is seen.
  - Deassert req, or present the next request, at the edge ending the gnt cycle.
  - A request held high through the IDLE cycle after its gnt is treated as a new request.
- Simultaneous events: rvalid for the previous read and sampling of a new request may occur in the same IDLE cycle; both are required.
- Write accesses never pulse rvalid and leave rdata unchanged.
- ram_addr and ram_wdata hold their last values in IDLE; only ram_en/ram_we qualify them.
- Reset mid-ACCESS: ram_en/ram_we drop immediately (asynchronously), so no write is committed if rst_n falls before the edge; pending rvalid is lost.
- Address range: any ADDR_WIDTH value is legal; no bounds checking.

Optional Feature:
- Macro: RAM_ARB_LOCK_EN.
- With the macro defined:
  - Adds inputs cpu_lock and spi_lock (1 bit each).
  - If the winner's lock is high at its grant, the following IDLE cycles consider only that port while its lock stays high. The other port's req is ignored, so an SPI burst load cannot be interleaved.
  - Dropping lock restores round-robin in the same IDLE cycle.
  - Reset clears the lock owner.
- Without the macro: the lock ports do not exist and arbitration is pure round-robin.

Decomposition:
- Package ram_arb_pkg:
  - state enum arb_state_t {IDLE, ACCESS}.
  - Port index constants PORT_CPU = 0, PORT_SPI = 1.
- One sub-module, rr_pick2: combinational two-way round-robin winner select with inputs req[1:0], last, and optional lock owner.

Test Plan:
- Reset, then single CPU read of addr 0x00 (RAM word 0x0122_0000) → cpu_gnt in cycle N+1; cpu_rvalid with cpu_rdata = 0x0122_0000 in N+2; spi_* stay 0.
- SPI write addr 0x10 data 0xDEAD_BEEF, then CPU read addr 0x10 → cpu_rdata = 0xDEAD_BEEF; spi_rvalid never asserts.
- cpu_req and spi_req asserted together and held for 4 accesses → grant order CPU, SPI, CPU, SPI, with gnt pulses spaced 2 cycles apart.
- CPU reads continuously while the SPI writes once → SPI granted within 2 accesses; no CPU starvation afterwards.
- rst_n pulled low mid-ACCESS of an SPI write to 0x20 → ram_en drops immediately; mem[0x20] unchanged; all outputs 0.
- With RAM_ARB_LOCK_EN: spi_lock held over 3 SPI writes while cpu_req is high → 3 consecutive spi_gnt; cpu_gnt only after spi_lock drops.
